// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - field-element types and widths shared by the fe_* blocks
package fe_pkg;
    localparam int FE_W   = 320;
    localparam int LIMBS  = 10;
    localparam int LIMB_W = 32;

    typedef logic signed [FE_W-1:0] fe_t;
    typedef logic [LIMB_W-1:0]      limb_t;
endpackage

// File: rtl/fe_add.sv
// rtl/fe_add.sv - combinational limb-wise field-element add
// Each limb wraps mod 2^32 on its own; carry and reduction are left to the caller.
module fe_add
    import fe_pkg::*;
(
    input  fe_t f,
    input  fe_t g,
    output fe_t h
);
    always_comb begin
        h = '0;
        for (int k = 0; k < LIMBS; k++) begin
            h[k*LIMB_W +: LIMB_W] = limb_t'(f[k*LIMB_W +: LIMB_W] + g[k*LIMB_W +: LIMB_W]);
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant with registered priority pointer
// The pointer moves to one past the winner only when the grant is consumed.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_idx
);
    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   w_rot;
    logic [IDW:0]   w_sum;

    // Rotate so bit 0 is the requester at the pointer.
    assign w_rot = N'({req, req} >> r_ptr);

    always_comb begin
        grant_valid = 1'b0;
        w_sum       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                grant_valid = 1'b1;
                w_sum       = {1'b0, r_ptr} + (IDW+1)'(k);
            end
        end
        if (w_sum >= (IDW+1)'(N)) begin
            w_sum = w_sum - (IDW+1)'(N);
        end
        grant_idx = w_sum[IDW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end
endmodule

// File: rtl/fe_add_arbiter.sv
// rtl/fe_add_arbiter.sv - round-robin sharing of one fe_add among NREQ requesters
// One-entry registered response buffer that refills in the same cycle it drains.
module fe_add_arbiter
    import fe_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FE_W-1:0] req_f,
    input  logic [NREQ*FE_W-1:0] req_g,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [FE_W-1:0]      rsp_h,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic [31:0]          op_count
);
    logic            w_gvalid;
    logic [IDW-1:0]  w_gidx;
    logic            w_can_accept;
    logic            w_accept;
    fe_t             w_f;
    fe_t             w_g;
    fe_t             w_h;

    logic            r_valid;
    logic [FE_W-1:0] r_h;
    logic [IDW-1:0]  r_id;
    logic [31:0]     r_count;

    assign w_can_accept = !r_valid || rsp_ready;
    assign w_accept     = w_can_accept && w_gvalid;

    rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .advance     (w_accept),
        .grant_valid (w_gvalid),
        .grant_idx   (w_gidx)
    );

    always_comb begin
        req_ready = '0;
        w_f       = '0;
        w_g       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IDW'(i)) begin
                req_ready[i] = w_accept;
                w_f          = req_f[i*FE_W +: FE_W];
                w_g          = req_g[i*FE_W +: FE_W];
            end
        end
    end

    fe_add u_add (
        .f (w_f),
        .g (w_g),
        .h (w_h)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_h     <= '0;
            r_id    <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_h     <= w_h;
            r_id    <= w_gidx;
            r_count <= r_count + 32'd1;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_h     = r_h;
    assign rsp_id    = r_id;
    assign busy      = r_valid;
    assign op_count  = r_count;
endmodule

// File: tb/tb_fe_add_arbiter.sv
// tb/tb_fe_add_arbiter.sv - directed scoreboard bench for fe_add_arbiter
module tb_fe_add_arbiter;
    localparam int N = 4;
    localparam int W = 320;

    typedef struct {
        int           id;
        logic [W-1:0] h;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_f;
    logic [N*W-1:0] req_g;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_h;
    logic [1:0]     rsp_id;
    logic           busy;
    logic [31:0]    op_count;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           m_ptr;
    int           m_count;
    bit           m_valid;
    logic [N-1:0] persist;
    logic [W-1:0] held_h;

    fe_add_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_f     (req_f),
        .req_g     (req_g),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_h     (rsp_h),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input logic [31:0] v);
        return {10{v}};
    endfunction

    function automatic logic [W-1:0] rnd_fe();
        logic [W-1:0] v;
        for (int k = 0; k < 10; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [W-1:0] model_add(input logic [W-1:0] f, input logic [W-1:0] g);
        logic [W-1:0] h;
        for (int k = 0; k < 10; k++) h[k*32 +: 32] = f[k*32 +: 32] + g[k*32 +: 32];
        return h;
    endfunction

    function automatic int m_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic post(input int p, input logic [W-1:0] f, input logic [W-1:0] g);
        req_f[p*W +: W] = f;
        req_g[p*W +: W] = g;
        req_valid[p]    = 1'b1;
    endtask

    // Entered and left at a falling edge; one clock of stimulus plus checking.
    task automatic tick();
        int           g;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        #2;
        g = (m_valid && !rsp_ready) ? -1 : m_grant(req_valid, m_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", W'(req_ready), W'(exp_rdy));
        chk("rsp_valid", W'(rsp_valid), W'(m_valid));
        chk("busy", W'(busy), W'(m_valid));
        chk("op_count", W'(op_count), W'(m_count));
        if (m_valid && rsp_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_id", W'(rsp_id), W'(e.id));
            chk("rsp_h", rsp_h, e.h);
        end
        if (g >= 0) begin
            e.id = g;
            e.h  = model_add(req_f[g*W +: W], req_g[g*W +: W]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
            m_count++;
            if (persist[g]) post(g, rnd_fe(), rnd_fe());
            else req_valid[g] = 1'b0;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_valid = 1'b0;
        m_ptr   = 0;
        m_count = 0;
        sb.delete();
        @(negedge clk);
        chk("rst_valid", W'(rsp_valid), W'(0));
        chk("rst_h", rsp_h, '0);
        chk("rst_id", W'(rsp_id), W'(0));
        chk("rst_count", W'(op_count), W'(0));
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_f     = '0;
        req_g     = '0;
        persist   = '0;
        @(negedge clk);
        do_reset();

        // single add on port 2
        rsp_ready = 1'b1;
        post(2, fill(32'h1), fill(32'h2));
        tick();
        chk("single_id", W'(rsp_id), W'(2));
        chk("single_h", rsp_h, fill(32'h3));
        chk("single_cnt", W'(op_count), W'(1));
        tick();

        // limb wrap without carry
        post(0, W'(32'hFFFF_FFFF), W'(32'h1));
        tick();
        chk("wrap_h", rsp_h, '0);
        tick();

        // round-robin fairness
        do_reset();
        for (int p = 0; p < N; p++) post(p, rnd_fe(), rnd_fe());
        persist = '1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_id", W'(rsp_id), W'(k % N));
        end
        chk("rr_cnt", W'(op_count), W'(8));
        persist   = '0;
        req_valid = '0;
        tick();

        // backpressure
        post(1, rnd_fe(), rnd_fe());
        post(3, rnd_fe(), rnd_fe());
        tick();
        chk("bp_first", W'(rsp_id), W'(1));
        held_h    = sb[0].h;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_id", W'(rsp_id), W'(1));
            chk("bp_h", rsp_h, held_h);
            chk("bp_rdy", W'(req_ready), W'(0));
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_next", W'(rsp_id), W'(3));
        tick();

        // reset while a response is stalled
        post(1, rnd_fe(), rnd_fe());
        tick();
        rsp_ready = 1'b0;
        tick();
        post(2, rnd_fe(), rnd_fe());
        post(0, rnd_fe(), rnd_fe());
        do_reset();
        rsp_ready = 1'b1;
        tick();
        chk("post_rst_id", W'(rsp_id), W'(0));
        tick();
        chk("post_rst_id2", W'(rsp_id), W'(2));
        tick();

        // pointer holds across idle cycles
        post(1, rnd_fe(), rnd_fe());
        tick();
        chk("idle_first", W'(rsp_id), W'(1));
        for (int k = 0; k < 10; k++) tick();
        post(0, rnd_fe(), rnd_fe());
        post(2, rnd_fe(), rnd_fe());
        tick();
        chk("idle_p2", W'(rsp_id), W'(2));
        tick();
        chk("idle_p0", W'(rsp_id), W'(0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fe_add_arbiter.md
Name: fe_add_arbiter

Overview:
- Shares one combinational fe_add instance (ten 32-bit limbs, limb-wise add) between NREQ requesters, for example the point-add and point-double sequencers.
- Arbitration is round-robin with a valid/ready handshake on each request port.
- The result is registered once and returned on a single response channel, tagged with the requester index.
- Sits between the curve-operation sequencers and the field adder.

Parameters:
- NREQ, 4, number of requester ports (1..8).
- IDW, $clog2(NREQ) with minimum 1, width of the requester index.
- FE_W, 320, field-element width (10 x 32-bit limbs). Fixed; not to be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept strobe.
- req_f  in  NREQ*FE_W  operand f; requester i occupies bits [i*320 +: 320].
- req_g  in  NREQ*FE_W  operand g, same packing as req_f.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready.
- rsp_h  out  FE_W  sum, {h9..h0}.
- rsp_id  out  IDW  index of the requester that owns rsp_h.
- busy  out  1  equals rsp_valid.
- op_count  out  32  number of accepted requests since reset; wraps.

Behaviour:
- Reset is synchronous, taken on the clk edge while rst=1. It clears:
  - rsp_valid=0, rsp_h=0, rsp_id=0
  - op_count=0
  - rr_ptr=0
- Reset overrides any accept or drain in that cycle. An in-flight response is discarded.
- can_accept = !rsp_valid || rsp_ready. This gives a one-entry output buffer that passes through on drain.
- Grant is combinational:
  - Scan req_valid starting at index rr_ptr and going up, wrapping modulo NREQ.
  - The first asserted index wins.
  - If no request is valid, there is no grant.
- req_ready[i] = can_accept && grant_valid && grant_idx==i. At most one bit is set. req_ready never asserts for a port whose valid is low.
- An accept is req_valid[i] && req_ready[i] on a clock edge. On that edge:
  - rsp_h <= fe_add(req_f[i], req_g[i])
  - rsp_id <= i
  - rsp_valid <= 1
  - rr_ptr <= (i+1) mod NREQ
  - op_count <= op_count+1
- Latency is 1 cycle from accept to rsp_valid. Throughput is 1 operation per cycle while rsp_ready=1.
- Drain without a new accept: rsp_valid && rsp_ready && no accept gives rsp_valid <= 0. rsp_h and rsp_id hold their old values.
- Simultaneous drain and accept: the new result replaces the old one and rsp_valid stays 1.
- Stall (rsp_valid && !rsp_ready):
  - rsp_h and rsp_id hold stable.
  - No accept occurs.
  - rr_ptr is unchanged.
- rr_ptr advances only on an accept, never on idle cycles.
- Arithmetic follows fe_add: each limb is (f_k + g_k) mod 2^32. There is no carry between limbs and no reduction. Carry and reduce are the caller's job.
- Requester protocol: once req_valid is raised it is held, with f and g stable, until accepted. The arbiter does not check this. The bench flags violations.
- NREQ=1: the port is always granted when valid; rr_ptr stays 0.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants rotate 0,1,..,NREQ-1,0. Each requester waits at most NREQ-1 accepts.

Decomposition:
- Shared package fe_pkg holds:
  - FE_W=320, LIMBS=10, LIMB_W=32
  - typedef fe_t (logic signed [319:0])
  - typedef limb_t
- One sub-module, rr_arbiter #(N), provides the combinational round-robin grant and the rr_ptr register:
  - inputs: req, advance
  - outputs: grant_valid, grant_idx
  - It is reused later for the fe_mul arbiter.
- fe_add is instantiated unchanged, once.
- The top level holds the operand mux, the output register and op_count.

Test Plan:
- Reset mid-stream: rst=1 while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, rsp_h=0, rsp_id=0, op_count=0, and the next grant goes to port 0.
- Single add:
  - Stimulus: port 2, f limbs all 0x00000001, g limbs all 0x00000002, rsp_ready=1.
  - Expect: req_ready[2]=1 for one cycle. Next cycle rsp_valid=1, every limb of rsp_h is 0x00000003, rsp_id=2, op_count=1.
- Limb wrap: f limb0=0xFFFFFFFF, g limb0=0x00000001, other limbs 0 -> rsp_h limb0=0x00000000, limb1=0 (no carry propagates).
- Round-robin:
  - Stimulus: all 4 ports valid continuously, rsp_ready=1, for 8 cycles.
  - Expect: rsp_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles, op_count=8.
- Backpressure:
  - Stimulus: ports 1 and 3 valid, rsp_ready=0 for 5 cycles after the first accept.
  - Expect: rsp_h and rsp_id=1 are stable and req_ready=0 throughout. When rsp_ready rises, port 3 is accepted in that same cycle and rsp_id=3 appears the next cycle.
- Idle pointer hold: accept port 1, go idle for 10 cycles, then ports 0 and 2 become valid together -> port 2 is granted first (rr_ptr=2), then port 0.
